// File: rtl/sd_dac.sv
// sd_dac: second-order sigma-delta DAC with 128x linear interpolation and a one-deep sample buffer
module sd_dac #(
  parameter int DW       = 12,
  parameter int OSR_LOG2 = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          sample_req,
  output logic          underrun,
  output logic          dout
);
  localparam int AW = DW + OSR_LOG2;
  localparam int SW = 24;
  localparam logic [DW-1:0] MID = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [SW+1:0] FB = {{(SW+1-AW){1'b0}}, 1'b1, {AW{1'b0}}};
  localparam logic signed [SW+1:0] SMAX = {3'b000, {(SW-1){1'b1}}};
  localparam logic signed [SW+1:0] SMIN = -SMAX;

  logic [OSR_LOG2-1:0] ph_q, ph_d;
  logic                full_q, full_d;
  logic [DW-1:0]       pend_q, pend_d, prev_q, prev_d, tgt;
  logic [AW-1:0]       acc_q, acc_d;
  logic signed [DW:0]  dlt_q, dlt_d;
  logic signed [SW-1:0] s1_q, s1_d, s2_q, s2_d;
  logic signed [SW+1:0] u, fb, s1_sum, s2_sum;
  logic                dout_q, bnd, accept, y;

  function automatic logic signed [SW-1:0] sat(input logic signed [SW+1:0] v);
    return (v > SMAX) ? SMAX[SW-1:0] : (v < SMIN) ? SMIN[SW-1:0] : v[SW-1:0];
  endfunction

  assign bnd        = &ph_q;
  assign accept     = din_valid & ~full_q;
  assign din_ready  = ~full_q;
  assign sample_req = bnd;
  assign underrun   = bnd & ~full_q & ~din_valid;
  assign dout       = dout_q;
  assign y          = ~s2_q[SW-1];

  // sample buffer, target selection and linear-ramp interpolator
  always_comb begin
    tgt    = full_q ? pend_q : din_valid ? din : prev_q;
    ph_d   = ph_q + {{(OSR_LOG2-1){1'b0}}, 1'b1};
    full_d = bnd ? 1'b0 : full_q | accept;
    pend_d = (accept & ~bnd) ? din : pend_q;
    prev_d = bnd ? tgt : prev_q;
    dlt_d  = bnd ? $signed({1'b0, tgt}) - $signed({1'b0, prev_q}) : dlt_q;
    acc_d  = bnd ? {prev_q, {OSR_LOG2{1'b0}}} : acc_q + {{(AW-DW-1){dlt_q[DW]}}, dlt_q};
  end

  // saturating double integrator fed back by the 1-bit quantizer
  always_comb begin
    u      = $signed({{(SW+2-AW){1'b0}}, acc_q});
    fb     = y ? FB : '0;
    s1_sum = {{2{s1_q[SW-1]}}, s1_q} + u - fb;
    s1_d   = sat(s1_sum);
    s2_sum = {{2{s2_q[SW-1]}}, s2_q} + {{2{s1_d[SW-1]}}, s1_d} - fb;
    s2_d   = sat(s2_sum);
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q   <= '0;
      full_q <= 1'b0;
      pend_q <= '0;
      prev_q <= MID;
      acc_q  <= {MID, {OSR_LOG2{1'b0}}};
      dlt_q  <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      dout_q <= 1'b0;
    end else begin
      ph_q   <= ph_d;
      full_q <= full_d;
      pend_q <= pend_d;
      prev_q <= prev_d;
      acc_q  <= acc_d;
      dlt_q  <= dlt_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      dout_q <= y;
    end
  end
endmodule
